// File: rtl/vc4000_cart_upload_if.sv
// Cartridge RAM read port shared between the upload engine (master) and the RAM (slave).
interface vc4000_cart_upload_if #(
   parameter int ADDR_W = 13
);
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd;
   logic              mem_busy;
   logic [7:0]        mem_q;

   modport master (output mem_addr, output mem_rd, input mem_busy, input mem_q);
   modport slave  (input mem_addr, input mem_rd, output mem_busy, output mem_q);
endinterface

// File: rtl/vc4000_cart_upload.sv
// HPS upload read-back: serves ioctl_rd from cartridge RAM, pads past cart_size.
// Latency 2+MEM_LAT cycles per in-range byte; mem_busy stalls the request and stretches ioctl_wait.
module vc4000_cart_upload #(
   parameter int          ADDR_W   = 13,
   parameter int          MEM_LAT  = 1,
   parameter logic [7:0]  PAD_BYTE = 8'hFF
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 ioctl_upload,
   input  logic                 ioctl_rd,
   input  logic [24:0]          ioctl_addr,
   output logic [7:0]           ioctl_din,
   output logic                 ioctl_wait,
   input  logic [ADDR_W:0]      cart_size,
   vc4000_cart_upload_if.master mem,
   output logic                 upload_active,
   output logic [ADDR_W:0]      upload_count,
   output logic                 upload_done
);
   localparam int              LAT_W   = 2;
   localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_LAT} state_t;

   state_t              state_q, state_d;
   logic [LAT_W-1:0]    lat_q, lat_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [7:0]          din_q, din_d;
   logic [ADDR_W:0]     cnt_q, cnt_d, cnt_base;
   logic                act_q, done_q;
   logic                inc, mem_rd_w, in_range, rise;

   // Full-width compare so addresses beyond the RAM never alias back into it.
   assign in_range = ioctl_addr < 25'(cart_size);
   assign rise     = ioctl_upload & ~act_q;

   always_comb begin
      state_d  = state_q;
      lat_d    = lat_q;
      addr_d   = addr_q;
      din_d    = din_q;
      inc      = 1'b0;
      mem_rd_w = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (ioctl_rd && ioctl_upload) begin
               if (!in_range) begin
                  din_d = PAD_BYTE;
                  inc   = 1'b1;
               end else begin
                  addr_d  = ioctl_addr[ADDR_W-1:0];
                  state_d = S_REQ;
               end
            end
         end
         S_REQ: begin
            if (!ioctl_upload) begin
               state_d = S_IDLE;
            end else begin
               mem_rd_w = 1'b1;
               if (!mem.mem_busy) begin
                  lat_d   = LAT_W'(MEM_LAT - 1);
                  state_d = S_LAT;
               end
            end
         end
         S_LAT: begin
            if (!ioctl_upload) begin
               state_d = S_IDLE;
            end else if (lat_q == '0) begin
               din_d   = mem.mem_q;
               inc     = 1'b1;
               state_d = S_IDLE;
            end else begin
               lat_d = lat_q - 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A byte delivered in the session's first cycle counts after the clear.
      cnt_base = rise ? '0 : cnt_q;
      cnt_d    = (inc && cnt_base != CNT_MAX) ? cnt_base + 1'b1 : cnt_base;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         lat_q   <= '0;
         addr_q  <= '0;
         din_q   <= '0;
         cnt_q   <= '0;
         act_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         lat_q   <= lat_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         cnt_q   <= cnt_d;
         act_q   <= ioctl_upload;
         done_q  <= act_q & ~ioctl_upload;
      end
   end

   assign mem.mem_rd    = mem_rd_w;
   assign mem.mem_addr  = addr_q;
   assign ioctl_wait    = (state_q != S_IDLE) | (ioctl_rd & ioctl_upload & in_range);
   assign ioctl_din     = din_q;
   assign upload_active = act_q;
   assign upload_count  = cnt_q;
   assign upload_done   = done_q;
endmodule
